// File: rtl/line_unpack_fifo.sv
// FIFO of wide memory lines, each unpacked MSB-first into WIDTH-bit elements over a valid/ready port.
// Define LUB_STATS_EN to add saturating stat_lines/stat_elems/stat_drops counters.
module line_unpack_fifo #(
  parameter int unsigned FULL_WIDTH = 512,
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned LOG_DEPTH  = 4,
  localparam int unsigned MAX_ELEMS = FULL_WIDTH / WIDTH,
  localparam int unsigned IW        = $clog2(MAX_ELEMS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [FULL_WIDTH-1:0] wr_data,
  input  logic [IW-1:0]         wr_base,
  input  logic [IW-1:0]         wr_bound,
  input  logic                  wr_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WIDTH-1:0]      rd_data,
  output logic [IW-1:0]         rd_idx,
  output logic                  rd_line_end,
  output logic                  rd_last,
`ifdef LUB_STATS_EN
  output logic [31:0]           stat_lines,
  output logic [31:0]           stat_elems,
  output logic [31:0]           stat_drops,
`endif
  output logic [LOG_DEPTH:0]    lines
);

  localparam int unsigned DEPTH = 1 << LOG_DEPTH;
  localparam int unsigned LW    = LOG_DEPTH + 1;

  logic [FULL_WIDTH-1:0] data_mem  [DEPTH];
  logic [IW-1:0]         base_mem  [DEPTH];
  logic [IW-1:0]         bound_mem [DEPTH];
  logic [DEPTH-1:0]      last_mem;

  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nxt;
  logic [LOG_DEPTH:0]   lines_q, lines_d;
  logic [IW-1:0]        elem_q, elem_d;

  logic [IW-1:0] wr_bound_c;
  logic          wr_acc, empty_win, push, pop, line_end, line_pop;
  logic [31:0]   sel_lo;

  assign wr_bound_c = (wr_bound > IW'(MAX_ELEMS)) ? IW'(MAX_ELEMS) : wr_bound;
  assign wr_ready   = (lines_q != LW'(DEPTH));
  assign wr_acc     = wr_valid && wr_ready;
  assign empty_win  = (wr_base >= wr_bound_c);
  assign push       = wr_acc && !empty_win;

  assign rd_valid   = (lines_q != '0);
  assign pop        = rd_valid && rd_ready;
  assign line_end   = rd_valid && (elem_q == bound_mem[rd_ptr_q] - IW'(1));
  assign line_pop   = pop && line_end;
  assign rd_ptr_nxt = rd_ptr_q + LOG_DEPTH'(1);

  // elem_q only ever holds an index below the line bound, so the select stays in range
  assign sel_lo      = (MAX_ELEMS - 1 - 32'(elem_q)) * WIDTH;
  assign rd_data     = data_mem[rd_ptr_q][sel_lo +: WIDTH];
  assign rd_idx      = elem_q;
  assign rd_line_end = line_end;
  assign rd_last     = line_end && last_mem[rd_ptr_q];
  assign lines       = lines_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lines_d  = lines_q + LW'(push) - LW'(line_pop);
    elem_d   = elem_q;
    if (pop) elem_d = elem_q + IW'(1);
    if (push) wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
    if (line_pop) begin
      rd_ptr_d = rd_ptr_nxt;
      // Next line's base loads in the same cycle so there is no bubble between lines
      if (lines_q > LW'(1))  elem_d = base_mem[rd_ptr_nxt];
      else if (push)         elem_d = wr_base;
      else                   elem_d = '0;
    end else if (!rd_valid && push) begin
      elem_d = wr_base;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      lines_d  = '0;
      elem_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lines_q  <= '0;
      elem_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lines_q  <= lines_d;
      elem_q   <= elem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      data_mem[wr_ptr_q]  <= wr_data;
      base_mem[wr_ptr_q]  <= wr_base;
      bound_mem[wr_ptr_q] <= wr_bound_c;
      last_mem[wr_ptr_q]  <= wr_last;
    end
  end

`ifdef LUB_STATS_EN
  logic [31:0] stat_lines_q, stat_lines_d;
  logic [31:0] stat_elems_q, stat_elems_d;
  logic [31:0] stat_drops_q, stat_drops_d;

  always_comb begin
    stat_lines_d = stat_lines_q;
    stat_elems_d = stat_elems_q;
    stat_drops_d = stat_drops_q;
    if (!flush) begin
      if (push && stat_lines_q != '1)                  stat_lines_d = stat_lines_q + 32'd1;
      if (pop && stat_elems_q != '1)                   stat_elems_d = stat_elems_q + 32'd1;
      if (wr_acc && empty_win && stat_drops_q != '1)   stat_drops_d = stat_drops_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lines_q <= '0;
      stat_elems_q <= '0;
      stat_drops_q <= '0;
    end else begin
      stat_lines_q <= stat_lines_d;
      stat_elems_q <= stat_elems_d;
      stat_drops_q <= stat_drops_d;
    end
  end

  assign stat_lines = stat_lines_q;
  assign stat_elems = stat_elems_q;
  assign stat_drops = stat_drops_q;
`endif

endmodule

// File: tb/tb_line_unpack_fifo.sv
// Bench for line_unpack_fifo: directed and random steps against a queue-of-lines reference model.
module tb_line_unpack_fifo;

  localparam int FW = 512;
  localparam int W  = 64;
  localparam int ME = 8;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst, flush, wr_valid, wr_ready, wr_last, rd_valid, rd_ready;
  logic [FW-1:0] wr_data;
  logic [3:0]    wr_base, wr_bound, rd_idx;
  logic [W-1:0]  rd_data;
  logic          rd_line_end, rd_last;
  logic [4:0]    lines;
`ifdef LUB_STATS_EN
  logic [31:0]   stat_lines, stat_elems, stat_drops;
`endif

  always #5 clk = ~clk;

  line_unpack_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .wr_base     (wr_base),
    .wr_bound    (wr_bound),
    .wr_last     (wr_last),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_idx      (rd_idx),
    .rd_line_end (rd_line_end),
    .rd_last     (rd_last),
`ifdef LUB_STATS_EN
    .stat_lines  (stat_lines),
    .stat_elems  (stat_elems),
    .stat_drops  (stat_drops),
`endif
    .lines       (lines)
  );

  typedef struct {
    logic [FW-1:0] d;
    int            base;
    int            bound;
    bit            last;
  } line_t;

  line_t q[$];
  int    elem_m;
  int    s_lines, s_elems, s_drops;
  int    n_cmp, n_err;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    bit           le;
    chk("wr_ready", FW'(wr_ready), FW'(q.size() < DP));
    chk("lines", FW'(lines), FW'(q.size()));
    chk("rd_valid", FW'(rd_valid), FW'(q.size() != 0));
    if (q.size() != 0) begin
      e  = q[0].d[FW-1-W*elem_m -: W];
      le = (elem_m == q[0].bound - 1);
      chk("rd_idx", FW'(rd_idx), FW'(elem_m));
      chk("rd_data", FW'(rd_data), FW'(e));
      chk("rd_line_end", FW'(rd_line_end), FW'(le));
      chk("rd_last", FW'(rd_last), FW'(le && q[0].last));
    end else begin
      chk("rd_line_end_idle", FW'(rd_line_end), '0);
      chk("rd_last_idle", FW'(rd_last), '0);
    end
`ifdef LUB_STATS_EN
    chk("stat_lines", FW'(stat_lines), FW'(s_lines));
    chk("stat_elems", FW'(stat_elems), FW'(s_elems));
    chk("stat_drops", FW'(stat_drops), FW'(s_drops));
`endif
  endtask

  // Apply the effect of the upcoming clock edge to the reference model
  task automatic model_update();
    int sz;
    int b;
    bit new_head;
    line_t l;
    sz = q.size();
    new_head = (sz == 0);
    if (rst) begin
      q.delete();
      elem_m = 0; s_lines = 0; s_elems = 0; s_drops = 0;
    end else if (flush) begin
      q.delete();
      elem_m = 0;
    end else begin
      if (sz > 0 && rd_ready) begin
        s_elems++;
        if (elem_m == q[0].bound - 1) begin
          void'(q.pop_front());
          new_head = 1'b1;
        end else begin
          elem_m++;
        end
      end
      if (wr_valid && sz < DP) begin
        b = (int'(wr_bound) > ME) ? ME : int'(wr_bound);
        if (int'(wr_base) >= b) s_drops++;
        else begin
          l.d = wr_data; l.base = int'(wr_base); l.bound = b; l.last = wr_last;
          q.push_back(l);
          s_lines++;
        end
      end
      if (new_head && q.size() != 0) elem_m = q[0].base;
    end
  endtask

  task automatic tick();
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int base, input int bound, input bit last);
    wr_valid = 1'b1;
    wr_base  = 4'(base);
    wr_bound = 4'(bound);
    wr_last  = last;
    for (int i = 0; i < FW / 32; i++) wr_data[i*32 +: 32] = $urandom;
  endtask

  task automatic idle();
    wr_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; elem_m = 0;
    s_lines = 0; s_elems = 0; s_drops = 0;
    rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    wr_base = '0; wr_bound = '0; wr_last = 1'b0; wr_data = '0;
    @(posedge clk); #1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single full line streamed out
    rd_ready = 1'b1;
    put(0, 8, 0); tick(); idle();
    repeat (9) tick();

    // Mid-line start followed by a short tail
    put(5, 8, 0); tick();
    put(0, 3, 1); tick(); idle();
    repeat (7) tick();

    // Fill to full, hold off the 17th, then free one slot
    rd_ready = 1'b0;
    for (int i = 0; i < DP; i++) begin
      put(0, 8, $urandom_range(0, 1)); tick();
    end
    put(1, 8, 1);
    repeat (3) tick();
    rd_ready = 1'b1;
    repeat (10) tick();
    idle();
    repeat (140) tick();

    // Empty window dropped, oversize bound clamped
    put(3, 3, 0); tick();
    put(3, 12, 0); tick(); idle();
    repeat (7) tick();

    // Random back-pressure over four lines
    for (int i = 0; i < 4; i++) begin
      put($urandom_range(0, 6), $urandom_range(7, 8), $urandom_range(0, 1));
      rd_ready = $urandom_range(0, 1);
      tick();
    end
    idle();
    for (int i = 0; i < 60; i++) begin
      rd_ready = $urandom_range(0, 1);
      tick();
    end

    // Flush in the middle of a line
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(0, 8, 0); tick();
    end
    idle();
    rd_ready = 1'b1;
    repeat (4) tick();
    rd_ready = 1'b0;
    flush = 1'b1; tick();
    flush = 1'b0; tick();
    put(2, 6, 1); tick(); idle();
    rd_ready = 1'b1;
    repeat (6) tick();

    // Random soak including flush and reset
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) != 0) put($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
      else idle();
      rd_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 99) < 2);
      rst      = ($urandom_range(0, 199) < 1);
      tick();
    end
    idle(); flush = 1'b0; rst = 1'b0; rd_ready = 1'b1;
    repeat (150) tick();
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
